sync_edge_debounce: RTL and testbench
=====================================

SYNC_EDGE_DEBOUNCE -- requirements
Module: sync_edge_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical samples needed to accept a level change; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of event_cnt.
REQ-003 clk_des  input  1  destination-domain clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sync_in  input  1  level from the two-flop synchronizer output, already in the clk_des domain.
REQ-006 cnt_clr  input  1  synchronous clear of event_cnt.
REQ-007 level_out  output  1  debounced level.
REQ-008 rise_pulse  output  1  one-cycle pulse on an accepted 0->1 change.
REQ-009 fall_pulse  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-010 glitch  output  1  one-cycle pulse when a pending change is rejected.
REQ-011 event_cnt  output  CNT_W  saturating count of accepted rising changes.

Function
REQ-012 The FSM SHALL have exactly four states: STABLE_LOW, CHK_HIGH, STABLE_HIGH and CHK_LOW.
REQ-013 A stability counter (8 bits) SHALL count consecutive sampling edges on which sync_in differs from level_out.
REQ-014 STABLE_LOW, sync_in=1: if DEBOUNCE_CYCLES=1, go to STABLE_HIGH with acceptance (REQ-016) on the same edge; otherwise go to CHK_HIGH with counter=1.
REQ-015 CHK_HIGH, sync_in=1: increment the counter; stay in CHK_HIGH while the counter is below DEBOUNCE_CYCLES.
REQ-016 Acceptance: on the edge where the DEBOUNCE_CYCLES-th consecutive sample of 1 is taken, go to STABLE_HIGH, register level_out=1 and rise_pulse=1, increment event_cnt, and clear the counter.
REQ-017 CHK_HIGH, sync_in=0: return to STABLE_LOW, clear the counter, and pulse glitch for one cycle; level_out stays unchanged.
REQ-018 STABLE_HIGH and CHK_LOW SHALL mirror REQ-014..REQ-017 with polarities inverted: acceptance gives level_out=0 and fall_pulse=1; event_cnt does not change.
REQ-019 Latency: level_out and the edge pulse SHALL be visible in the cycle after the DEBOUNCE_CYCLES-th consistent sampling edge; there is no combinational path from sync_in to any output.
REQ-020 rise_pulse, fall_pulse and glitch SHALL each be high for exactly one clk_des cycle per event and never assert together.
REQ-021 event_cnt SHALL saturate at 2^CNT_W-1 and not wrap; rise_pulse still fires at saturation.
REQ-022 cnt_clr=1 SHALL set event_cnt to 0 on the next edge; cnt_clr wins over a simultaneous increment, giving 0.
REQ-023 Stable states with sync_in equal to level_out SHALL hold all state and leave all pulses low.

Reset
REQ-024 On rst=1, immediately and regardless of clock: state=STABLE_LOW, counter=0, level_out=0, rise_pulse=0, fall_pulse=0, glitch=0, event_cnt=0.
REQ-025 A reset asserted mid-check SHALL discard the pending change with no pulse at any time; after release, the first edge with sync_in=1 starts a fresh count from 1.
REQ-026 Release of rst SHALL be taken as synchronous to clk_des; the first active edge after release follows REQ-014.

Verification
REQ-027 Default parameters, reset, sync_in=1 held: on the 4th sampling edge level_out goes 1 and rise_pulse pulses for 1 cycle; event_cnt=1.
REQ-028 sync_in=1 for 3 edges then 0: glitch pulses once; level_out stays 0; event_cnt stays 0; no rise_pulse.
REQ-029 From STABLE_HIGH, sync_in=0 for 4 edges: fall_pulse pulses once; level_out=0; event_cnt unchanged.
REQ-030 CNT_W=2, 5 accepted rises: event_cnt reads 1,2,3,3,3; rise_pulse fires 5 times.
REQ-031 cnt_clr asserted in the same cycle as an accepting edge: event_cnt=0 next cycle; rise_pulse still pulses.
REQ-032 DEBOUNCE_CYCLES=1: each sync_in toggle gives the matching pulse in the next cycle and glitch never asserts; rst asserted mid-CHK_HIGH at default parameters clears all outputs immediately with no pulse.

Source files
------------

// File: rtl/sync_edge_debounce.sv
// Debounces an already-synchronised level: a change is accepted only after
// DEBOUNCE_CYCLES consecutive differing samples. Emits edge/glitch pulses and counts rises.
module sync_edge_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk_des,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             glitch,
    output logic [CNT_W-1:0] event_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    localparam logic [7:0]       DC_L     = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    state_t           state_q, state_d;
    logic [7:0]       stab_cnt_q, stab_cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;

    logic [7:0]       stab_inc;
    logic             reached;
    logic             accept_rise;
    logic             accept_fall;
    logic             reject;

    assign stab_inc = stab_cnt_q + 8'd1;
    assign reached  = (stab_inc >= DC_L);

    always_ff @(posedge clk_des or posedge rst) begin
        if (rst) begin
            state_q     <= STABLE_LOW;
            stab_cnt_q  <= 8'd0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            glitch_q    <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            glitch_q    <= glitch_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        reject      = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_in) begin
                    if (SINGLE) begin
                        state_d     = STABLE_HIGH;
                        stab_cnt_d  = 8'd0;
                        accept_rise = 1'b1;
                    end else begin
                        state_d    = CHK_HIGH;
                        stab_cnt_d = 8'd1;
                    end
                end
            end
            CHK_HIGH: begin
                if (!sync_in) begin
                    state_d    = STABLE_LOW;
                    stab_cnt_d = 8'd0;
                    reject     = 1'b1;
                end else if (reached) begin
                    state_d     = STABLE_HIGH;
                    stab_cnt_d  = 8'd0;
                    accept_rise = 1'b1;
                end else begin
                    stab_cnt_d = stab_inc;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    if (SINGLE) begin
                        state_d     = STABLE_LOW;
                        stab_cnt_d  = 8'd0;
                        accept_fall = 1'b1;
                    end else begin
                        state_d    = CHK_LOW;
                        stab_cnt_d = 8'd1;
                    end
                end
            end
            CHK_LOW: begin
                if (sync_in) begin
                    state_d    = STABLE_HIGH;
                    stab_cnt_d = 8'd0;
                    reject     = 1'b1;
                end else if (reached) begin
                    state_d     = STABLE_LOW;
                    stab_cnt_d  = 8'd0;
                    accept_fall = 1'b1;
                end else begin
                    stab_cnt_d = stab_inc;
                end
            end
            default: begin
                state_d    = STABLE_LOW;
                stab_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        level_d  = level_q;
        rise_d   = accept_rise;
        fall_d   = accept_fall;
        glitch_d = reject;
        if (accept_rise) level_d = 1'b1;
        if (accept_fall) level_d = 1'b0;
        // Clear takes priority over a same-edge increment.
        event_cnt_d = event_cnt_q;
        if (cnt_clr) begin
            event_cnt_d = '0;
        end else if (accept_rise && (event_cnt_q != CNT_MAX)) begin
            event_cnt_d = event_cnt_q + 1'b1;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch     = glitch_q;
    assign event_cnt  = event_cnt_q;

endmodule

// File: tb/tb_sync_edge_debounce.sv
// Bench for sync_edge_debounce: three parameterisations share one stimulus stream
// and are checked against a run-length reference model, tables and directed sequences.
module tb_sync_edge_debounce;

    logic clk;
    logic rst;
    logic sin;
    logic clr;
    logic lvl  [3];
    logic rise [3];
    logic fall [3];
    logic gl   [3];
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;

    int dc_a  [3] = '{4, 4, 1};
    int max_a [3] = '{255, 3, 255};

    int m_lvl [3];
    int m_run [3];
    int m_rise[3];
    int m_fall[3];
    int m_gl  [3];
    int m_cnt [3];

    typedef struct {
        logic sin;
        logic clr;
        logic lvl;
        logic rise;
        logic fall;
        logic gl;
        int   cnt;
    } vec_t;
    vec_t vecs[$];

    sync_edge_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk_des(clk), .rst(rst), .sync_in(sin), .cnt_clr(clr),
        .level_out(lvl[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]),
        .glitch(gl[0]), .event_cnt(cnt0));
    sync_edge_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut1 (
        .clk_des(clk), .rst(rst), .sync_in(sin), .cnt_clr(clr),
        .level_out(lvl[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]),
        .glitch(gl[1]), .event_cnt(cnt1));
    sync_edge_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut2 (
        .clk_des(clk), .rst(rst), .sync_in(sin), .cnt_clr(clr),
        .level_out(lvl[2]), .rise_pulse(rise[2]), .fall_pulse(fall[2]),
        .glitch(gl[2]), .event_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int act_cnt(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    // Reference: a change is accepted once the run of samples differing from
    // the current level reaches DC; a broken run is a glitch.
    task automatic model_step(input int i);
        m_rise[i] = 0;
        m_fall[i] = 0;
        m_gl[i]   = 0;
        if (rst) begin
            m_lvl[i] = 0;
            m_run[i] = 0;
            m_cnt[i] = 0;
        end else begin
            if (int'(sin) != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == dc_a[i]) begin
                    m_lvl[i] = int'(sin);
                    m_run[i] = 0;
                    if (sin) m_rise[i] = 1;
                    else     m_fall[i] = 1;
                end
            end else begin
                if (m_run[i] > 0) m_gl[i] = 1;
                m_run[i] = 0;
            end
            if (clr) m_cnt[i] = 0;
            else if (m_rise[i] == 1 && m_cnt[i] < max_a[i]) m_cnt[i]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            chk($sformatf("lvl%0d", i),  int'(lvl[i]),  m_lvl[i]);
            chk($sformatf("rise%0d", i), int'(rise[i]), m_rise[i]);
            chk($sformatf("fall%0d", i), int'(fall[i]), m_fall[i]);
            chk($sformatf("gl%0d", i),   int'(gl[i]),   m_gl[i]);
            chk($sformatf("cnt%0d", i),  act_cnt(i),    m_cnt[i]);
            chk($sformatf("excl%0d", i),
                int'((int'(rise[i]) + int'(fall[i]) + int'(gl[i])) > 1), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_lvl[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
            m_rise[i] = 0; m_fall[i] = 0; m_gl[i] = 0;
        end
        #1;
        chk("rst_lvl", int'(lvl[0]), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_pulses", int'(rise[0]) + int'(fall[0]) + int'(gl[0]), 0);
        tick();
        tick();
        rst = 1'b0;

        //              sin   clr   lvl   rise  fall  gl   cnt
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0});

        foreach (vecs[k]) begin
            sin = vecs[k].sin;
            clr = vecs[k].clr;
            tick();
            $display("vec %0d sin=%0b clr=%0b -> lvl=%0b rise=%0b fall=%0b gl=%0b cnt=%0d",
                     k, sin, clr, lvl[0], rise[0], fall[0], gl[0], cnt0);
            chk($sformatf("vec%0d_lvl", k),  int'(lvl[0]),  int'(vecs[k].lvl));
            chk($sformatf("vec%0d_rise", k), int'(rise[0]), int'(vecs[k].rise));
            chk($sformatf("vec%0d_fall", k), int'(fall[0]), int'(vecs[k].fall));
            chk($sformatf("vec%0d_gl", k),   int'(gl[0]),   int'(vecs[k].gl));
            chk($sformatf("vec%0d_cnt", k),  int'(cnt0),    vecs[k].cnt);
        end
        clr = 1'b0;

        // Saturation of the 2-bit counter over five accepted rises.
        rst = 1'b1;
        sin = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sin = 1'b1;
            repeat (4) tick();
            $display("sat rise %0d: rise=%0b cnt=%0d", i, rise[1], cnt1);
            chk($sformatf("sat%0d_rise", i), int'(rise[1]), 1);
            chk($sformatf("sat%0d_cnt", i), int'(cnt1), (i < 3) ? i : 3);
            sin = 1'b0;
            repeat (4) tick();
        end

        // Asynchronous reset in the middle of a pending rise.
        sin = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        $display("async rst mid-check: lvl=%0b cnt=%0d", lvl[0], cnt0);
        chk("arst_lvl", int'(lvl[0]), 0);
        chk("arst_cnt", int'(cnt0), 0);
        chk("arst_pulses", int'(rise[0]) + int'(fall[0]) + int'(gl[0]), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("fresh_no_accept", int'(lvl[0]), 0);
        tick();
        $display("fresh count after reset: lvl=%0b rise=%0b cnt=%0d", lvl[0], rise[0], cnt0);
        chk("fresh_rise", int'(rise[0]), 1);
        chk("fresh_cnt", int'(cnt0), 1);

        // Single-cycle debounce: every toggle is accepted on the next edge.
        for (int i = 0; i < 4; i++) begin
            sin = ~sin;
            tick();
            $display("dc1 toggle sin=%0b: rise=%0b fall=%0b gl=%0b", sin, rise[2], fall[2], gl[2]);
            if (sin) chk($sformatf("dc1_rise%0d", i), int'(rise[2]), 1);
            else     chk($sformatf("dc1_fall%0d", i), int'(fall[2]), 1);
            chk($sformatf("dc1_gl%0d", i), int'(gl[2]), 0);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) sin = ~sin;
            clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
